// File: rtl/irq_controller_6502.sv
// Memory-mapped interrupt controller for a 6502-style bus: edge-detected sources, W1C pending,
// mask, priority vector and a registered active-low IRQ. Define IRQ_CTRL_SYNC_EN to add input
// synchronizers.
module irq_controller_6502 #(
  parameter int unsigned BaseAddress   = 0,
  parameter int unsigned address_width = 16,
  parameter int unsigned data_width    = 8,
  parameter int unsigned NumSources    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     rd_wr_i,
  input  logic [NumSources-1:0]    irq_src_i,
  output logic                     irq_n_o
);

  typedef logic [address_width-1:0] addr_t;
  typedef logic [data_width-1:0]    data_t;

  localparam addr_t AddrPending = addr_t'(BaseAddress);
  localparam addr_t AddrMask    = addr_t'(BaseAddress + 1);
  localparam addr_t AddrActive  = addr_t'(BaseAddress + 2);
  localparam addr_t AddrVector  = addr_t'(BaseAddress + 3);
  localparam addr_t AddrForce   = addr_t'(BaseAddress + 4);

  // Bits at or above NumSources are held at zero through this mask.
  localparam data_t SrcMask = data_t'((64'd1 << NumSources) - 64'd1);

  data_t src_det;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NumSources-1:0] sync1_q, sync2_q;

  // Synchronizer keeps sampling through reset so the detector sees a settled level.
  always_ff @(posedge clk_i) begin
    sync1_q <= irq_src_i;
    sync2_q <= sync1_q;
  end

  assign src_det = data_t'(sync2_q);
`else
  assign src_det = data_t'(irq_src_i);
`endif

  data_t pending_q, pending_d;
  data_t mask_q, mask_d;
  data_t prev_q;
  data_t data_q, data_d;
  logic  irq_n_q;

  data_t active;
  data_t vector;
  data_t rise;
  logic  wr_pending, wr_mask, wr_force;

  always_comb begin
    active = pending_q & mask_q;

    // Scan high to low so the lowest-numbered active source is left in the index field.
    vector = '0;
    for (int i = NumSources - 1; i >= 0; i--) begin
      if (active[i]) begin
        vector[2:0] = 3'(i);
      end
    end
    vector[7] = |active;

    data_d = '0;
    if (!rd_wr_i) begin
      case (address_i)
        AddrPending: data_d = pending_q;
        AddrMask:    data_d = mask_q;
        AddrActive:  data_d = active;
        AddrVector:  data_d = vector;
        default:     data_d = '0;
      endcase
    end

    wr_pending = rd_wr_i && (address_i == AddrPending);
    wr_mask    = rd_wr_i && (address_i == AddrMask);
    wr_force   = rd_wr_i && (address_i == AddrForce);

    rise = src_det & ~prev_q & SrcMask;

    // A rising edge is OR-ed in after the clear so the set wins a same-cycle collision.
    pending_d = pending_q;
    if (wr_pending) begin
      pending_d = pending_d & ~data_i;
    end
    if (wr_force) begin
      pending_d = pending_d | data_i;
    end
    pending_d = (pending_d | rise) & SrcMask;

    mask_d = mask_q;
    if (wr_mask) begin
      mask_d = data_i & SrcMask;
    end
  end

  always_ff @(posedge clk_i) begin
    prev_q <= src_det;
    if (reset_i) begin
      pending_q <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      irq_n_q   <= 1'b1;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      irq_n_q   <= ~|active;
    end
  end

  assign data_o  = data_q;
  assign irq_n_o = irq_n_q;

endmodule

// File: tb/tb_irq_controller_6502.sv
// Randomized bench for irq_controller_6502 checked cycle by cycle against a register-level model.
module tb_irq_controller_6502;

  localparam int unsigned NS   = 6;
  localparam logic [15:0] BASE = 16'h0040;
  localparam logic [7:0]  VM   = 8'h3F;
`ifdef IRQ_CTRL_SYNC_EN
  localparam bit Sync = 1'b1;
`else
  localparam bit Sync = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic [15:0]   address_i;
  logic [7:0]    data_i;
  logic [7:0]    data_o;
  logic          rd_wr_i;
  logic [NS-1:0] irq_src_i;
  logic          irq_n_o;

  always #5 clk = ~clk;

  irq_controller_6502 #(
    .BaseAddress  (int'(BASE)),
    .address_width(16),
    .data_width   (8),
    .NumSources   (NS)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .address_i(address_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .rd_wr_i  (rd_wr_i),
    .irq_src_i(irq_src_i),
    .irq_n_o  (irq_n_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state, held as plain bytes.
  logic [7:0] m_pend = '0, m_mask = '0, m_dout = '0;
  logic [7:0] m_prev = '0, m_s1 = '0, m_s2 = '0;
  logic       m_irqn = 1'b1;
  logic [NS-1:0] src_cur = '0;

  function automatic logic [7:0] vec_of(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) return 8'h80 | 8'(i);
    end
    return 8'h00;
  endfunction

  task automatic model(input logic rst, input logic [15:0] addr, input logic wr,
                       input logic [7:0] din, input logic [7:0] src);
    logic [7:0] det, act, rd, nxt;
    int off;
    det = Sync ? m_s2 : src;
    if (rst) begin
      m_pend = '0;
      m_mask = '0;
      m_dout = '0;
      m_irqn = 1'b1;
    end else begin
      act = m_pend & m_mask;
      off = int'(addr) - int'(BASE);
      rd  = 8'h00;
      if (!wr) begin
        case (off)
          0: rd = m_pend;
          1: rd = m_mask;
          2: rd = act;
          3: rd = vec_of(act);
          default: rd = 8'h00;
        endcase
      end
      nxt = m_pend;
      if (wr && off == 0) nxt = nxt & ~din;
      if (wr && off == 4) nxt = nxt | din;
      nxt = (nxt | (det & ~m_prev)) & VM;
      if (wr && off == 1) m_mask = din & VM;
      m_irqn = (act == 8'h00);
      m_dout = rd;
      m_pend = nxt;
    end
    m_prev = det;
    m_s2   = m_s1;
    m_s1   = src;
  endtask

  task automatic step(input logic rst, input logic [15:0] addr, input logic wr,
                      input logic [7:0] din);
    reset_i   = rst;
    address_i = addr;
    rd_wr_i   = wr;
    data_i    = din;
    irq_src_i = src_cur;
    @(posedge clk);
    model(rst, addr, wr, din, 8'(src_cur));
    #1;
    check_eq("data_o", data_o, m_dout);
    check_eq("irq_n_o", {7'b0, irq_n_o}, {7'b0, m_irqn});
  endtask

  task automatic bus_wr(input int off, input logic [7:0] d);
    step(1'b0, BASE + 16'(off), 1'b1, d);
  endtask

  task automatic bus_rd(input int off);
    step(1'b0, BASE + 16'(off), 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 8'h00);
  endtask

  initial begin
    reset_i = 1'b1; address_i = '0; rd_wr_i = 1'b0; data_i = '0; irq_src_i = '0;

    // Source 2 held high through reset release must not set pending.
    src_cur = 6'h04;
    for (int i = 0; i < 4; i++) step(1'b1, BASE, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) bus_rd(0);
    src_cur = 6'h00; idle(3);
    src_cur = 6'h04; idle(3); bus_rd(0);
    bus_wr(0, 8'hFF); src_cur = 6'h00; idle(3);

    // Basic path, masking and priority.
    bus_wr(1, 8'h01);
    src_cur = 6'h01; idle(1); src_cur = 6'h00; idle(3);
    bus_rd(0); bus_rd(3); bus_wr(0, 8'h01); idle(2);
    bus_wr(1, 8'h00);
    src_cur = 6'h08; idle(1); src_cur = 6'h00; idle(3);
    bus_rd(0); bus_rd(2); bus_wr(1, 8'h08); idle(1); bus_rd(3);
    bus_wr(1, 8'hFF); bus_wr(4, 8'h24); bus_rd(3);
    bus_wr(0, 8'h04); bus_rd(3); bus_wr(0, 8'h20); bus_rd(3); idle(1);
    bus_wr(4, 8'hC0); bus_rd(0); bus_rd(1); bus_rd(4); bus_rd(5);
    bus_wr(2, 8'hFF); bus_wr(3, 8'hFF); bus_rd(2);

    // Set/clear collision on source 1, timed so the detector edge meets the W1C.
    bus_wr(4, 8'h02); src_cur = 6'h02;
    if (Sync) idle(2);
    bus_wr(0, 8'h02); bus_rd(0); src_cur = 6'h00; idle(3);

    // Reset mid-transaction discards the write.
    step(1'b1, BASE + 16'd4, 1'b1, 8'h3F); idle(1); bus_rd(0); bus_rd(1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic rst, wr;
      logic [15:0] addr;
      for (int b = 0; b < NS; b++) begin
        if ($urandom_range(0, 7) == 0) src_cur[b] = ~src_cur[b];
      end
      rst  = ($urandom_range(0, 99) < 2);
      wr   = ($urandom_range(0, 2) == 0);
      addr = ($urandom_range(0, 19) == 0) ? 16'($urandom)
                                          : BASE - 16'd2 + 16'($urandom_range(0, 8));
      step(rst, addr, wr, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
